// File: rtl/subnbit_serial.sv
// subnbit_serial: bit-serial N-bit subtractor, Diff = A - B mod 2^N, LSB first,
// one bit per clock through a single full-subtractor cell.
//
// Optional feature macro: SUB_SIGNED_OVF_EN (adds the Ovf port and its logic).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request; accepted in IDLE or DONE, ignored in RUN
//   A, B   minuend / subtrahend, captured on the accepting edge
//   busy   high while the FSM is in RUN
//   done   one-cycle pulse when Diff/Bout (and Ovf) are updated
//   Diff   A - B mod 2^N, held until the next completion
//   Bout   final borrow (A < B unsigned), held with Diff
//   Ovf    signed overflow (SUB_SIGNED_OVF_EN only)
module subnbit_serial #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Diff,
  output logic         Bout
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic         Ovf
`endif
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [N-1:0]    a_sh, b_sh, res, res_n;
  logic            br, br_n, d;
  logic [CW-1:0]   cnt;
  logic            accept, last;
`ifdef SUB_SIGNED_OVF_EN
  logic            a_msb, b_msb;
`endif

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == RUN) && (cnt == CW'(N - 1));

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    d     = a_sh[0] ^ b_sh[0] ^ br;
    br_n  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    // Written as shift-then-insert so N=1 needs no degenerate slice.
    res_n = res >> 1;
    res_n[N-1] = d;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // busy/done are flops fed from the next state so they change with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      Diff  <= '0;
      Bout  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      Ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= B;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
`ifdef SUB_SIGNED_OVF_EN
      a_msb <= A[N-1];
      b_msb <= B[N-1];
`endif
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      br   <= br_n;
      cnt  <= cnt + 1'b1;
      res  <= res_n;
      if (last) begin
        Diff <= res_n;
        Bout <= br_n;
`ifdef SUB_SIGNED_OVF_EN
        // d is the result MSB on the final bit.
        Ovf  <= (a_msb != b_msb) && (d != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_subnbit_serial.sv
module tb_subnbit_serial;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         busy, done, Bout;
  logic [N-1:0] Diff;
`ifdef SUB_SIGNED_OVF_EN
  logic         Ovf;
`endif

  subnbit_serial #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("busy_with_done", busy, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("diff", Diff, e.diff);
        chk("bout", Bout, e.bout);
`ifdef SUB_SIGNED_OVF_EN
        chk("ovf", Ovf, e.ovf);
`endif
      end
    end
  end

  // Counts negedges after the accepting edge until done; returns count and busy cycles.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        return;
      end
      if (busy) bcnt++;
    end
    chk("done_timeout", 1, 0);
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] ed, input logic eb, input logic eo);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    e.diff = ed; e.bout = eb; e.ovf = eo;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    A = 'x;
    B = 'x;
  endtask

  typedef struct {
    logic [N-1:0] a, b, d;
    logic         bo, ov;
  } vec_t;

  vec_t vecs[7] = '{
    '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0},
    '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0},
    '{8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0},
    '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1},
    '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1},
    '{8'h0F, 8'h01, 8'h0E, 1'b0, 1'b0},
    '{8'h01, 8'hFF, 8'h02, 1'b1, 1'b0}
  };

  initial begin
    int lat, bcnt, ndone;
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", Diff, 0);
    chk("rst_bout", Bout, 0);
    rst_n = 1'b1;

    // 5 - 3: latency and busy width.
    issue(8'd5, 8'd3, 8'd2, 1'b0, 1'b0);
    wait_done(lat, bcnt);
    chk("latency", lat, 9);
    chk("busy_cycles", bcnt, 8);

    // Directed table.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].ov);
      wait_done(lat, bcnt);
      chk("latency_tbl", lat, 9);
    end

    // Start while busy is ignored.
    issue(8'd20, 8'd10, 8'd10, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    A = 8'd1; B = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("single_done", ndone, 1);

    // Back-to-back: start held through DONE.
    issue(8'h30, 8'h10, 8'h20, 1'b0, 1'b0);
    begin
      exp_t e;
      e.diff = 8'd72; e.bout = 1'b0; e.ovf = 1'b0;
      exp_q.push_back(e);
    end
    A = 8'd100; B = 8'd28; start = 1'b1;
    wait_done(lat, bcnt);
    chk("b2b_lat1", lat, 9);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bcnt);
    chk("b2b_lat2", lat, 9);

    // Reset mid-operation: Diff currently holds 72.
    @(negedge clk);
    A = 8'h55; B = 8'h11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_diff", Diff, 0);
    chk("midrst_bout", Bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);

    // Operation resumes normally after reset.
    issue(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    wait_done(lat, bcnt);
    chk("latency_post_rst", lat, 9);
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
